lcd_cmd_sequencer: RTL and testbench

- Script-driven command issuer for LCD_CTRL.
- After `start`, fetches packed command words from a small command ROM (CROM) and drives `cmd`/`cmd_valid` into the LCD controller, obeying its busy handshake.
- Expands repeat counts; ends on a Write command and waits for the controller's `done`.
- Sits between the test/system host and LCD_CTRL. Replaces hand-driven command stimulus.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_seq_watchdog.sv | 40 ++++
 rtl/lcd_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: opcodes, script word
// layout, sequencer state encoding and a saturating counter helper.
package lcd_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 2;
    localparam int REP_LSB  = 3;
    localparam int REP_MSB  = 6;
    localparam int LAST_BIT = 7;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_INIT  = 4'd1,
        ST_FETCH = 4'd2,
        ST_LATCH = 4'd3,
        ST_ISSUE = 4'd4,
        ST_ACK   = 4'd5,
        ST_EXEC  = 4'd6,
        ST_WFIN  = 4'd7,
        ST_DONE  = 4'd8,
        ST_ERR   = 4'd9
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_seq_watchdog.sv
// Acknowledge watchdog: counts enabled cycles after a clear and flags the
// cycle in which the LIMIT-th enabled cycle is reached.
module lcd_seq_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then increment while enabled, parked at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(LIMIT - 1))) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Script-driven command issuer: walks a command ROM, expands repeat counts and
// strobes commands into LCD_CTRL while honouring its busy/done handshake.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int CROM_AW     = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               CROM_EN,
    output logic [CROM_AW-1:0] CROM_A,
    input  logic [7:0]         CROM_Q,
    input  logic               lcd_busy,
    input  logic               lcd_done,
    output logic [2:0]         cmd,
    output logic               cmd_valid,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_err,
    output logic [7:0]         issued_cnt
);
    seq_state_e state_q, state_d;

    logic               crom_en_q, crom_en_d;
    logic [CROM_AW-1:0] crom_a_q, crom_a_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               seq_busy_q, seq_busy_d;
    logic               seq_done_q, seq_done_d;
    logic               seq_err_q, seq_err_d;
    logic [7:0]         issued_cnt_q, issued_cnt_d;
    logic [2:0]         op_q, op_d;
    logic [3:0]         rep_cnt_q, rep_cnt_d;
    logic               last_q, last_d;

    logic start_s;
    logic issue_s;
    logic wd_expired_s;

    assign start_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign issue_s = (state_q == ST_ISSUE) && !lcd_busy;

    lcd_seq_watchdog #(
        .LIMIT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (issue_s),
        .enable  (state_q == ST_ACK),
        .expired (wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_INIT;
                else       state_d = state_q;
            end
            ST_INIT: begin
                if (!lcd_busy) state_d = ST_FETCH;
                else           state_d = ST_INIT;
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (!lcd_busy) state_d = ST_ACK;
                else           state_d = ST_ISSUE;
            end
            ST_ACK: begin
                // A busy rise in the same cycle as expiry still counts as acknowledged.
                if (lcd_busy)          state_d = ST_EXEC;
                else if (wd_expired_s) state_d = ST_ERR;
                else                   state_d = ST_ACK;
            end
            ST_EXEC: begin
                if (lcd_busy)                 state_d = ST_EXEC;
                else if (op_q == CMD_WRITE)   state_d = ST_WFIN;
                else if (rep_cnt_q != 4'd0)   state_d = ST_ISSUE;
                else if (last_q)              state_d = ST_DONE;
                else if (&crom_a_q)           state_d = ST_ERR;
                else                          state_d = ST_FETCH;
            end
            ST_WFIN: begin
                if (lcd_done) state_d = ST_DONE;
                else          state_d = ST_WFIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, all registered from the next state.
    always_comb begin
        crom_en_d    = (state_d == ST_FETCH) ? 1'b0 : 1'b1;
        seq_busy_d   = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
        seq_done_d   = (state_d == ST_DONE);
        seq_err_d    = (state_d == ST_ERR);
        cmd_valid_d  = issue_s;

        if (issue_s) cmd_d = op_q;
        else         cmd_d = cmd_q;

        if (start_s)      issued_cnt_d = 8'd0;
        else if (issue_s) issued_cnt_d = sat_inc8(issued_cnt_q);
        else              issued_cnt_d = issued_cnt_q;

        if (start_s)                                       crom_a_d = '0;
        else if ((state_q == ST_EXEC) && (state_d == ST_FETCH)) crom_a_d = crom_a_q + CROM_AW'(1);
        else                                               crom_a_d = crom_a_q;

        if (state_q == ST_LATCH) begin
            op_d      = CROM_Q[OP_MSB:OP_LSB];
            rep_cnt_d = CROM_Q[REP_MSB:REP_LSB];
            last_d    = CROM_Q[LAST_BIT];
        end else begin
            op_d   = op_q;
            last_d = last_q;
            if ((state_q == ST_EXEC) && (state_d == ST_ISSUE)) rep_cnt_d = rep_cnt_q - 4'd1;
            else                                               rep_cnt_d = rep_cnt_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crom_en_q    <= 1'b1;
            crom_a_q     <= '0;
            cmd_q        <= 3'd0;
            cmd_valid_q  <= 1'b0;
            seq_busy_q   <= 1'b0;
            seq_done_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            issued_cnt_q <= 8'd0;
            op_q         <= 3'd0;
            rep_cnt_q    <= 4'd0;
            last_q       <= 1'b0;
        end else begin
            crom_en_q    <= crom_en_d;
            crom_a_q     <= crom_a_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            seq_busy_q   <= seq_busy_d;
            seq_done_q   <= seq_done_d;
            seq_err_q    <= seq_err_d;
            issued_cnt_q <= issued_cnt_d;
            op_q         <= op_d;
            rep_cnt_q    <= rep_cnt_d;
            last_q       <= last_d;
        end
    end

    assign CROM_EN    = crom_en_q;
    assign CROM_A     = crom_a_q;
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign seq_busy   = seq_busy_q;
    assign seq_done   = seq_done_q;
    assign seq_err    = seq_err_q;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed self-checking bench for lcd_cmd_sequencer with a command ROM model,
// a simple LCD_CTRL busy model and a scoreboard of expected command strobes.
module tb_lcd_cmd_sequencer;
    localparam int AW  = 5;
    localparam int ATO = 15;

    logic          clk;
    logic          reset;
    logic          start;
    logic          CROM_EN;
    logic [AW-1:0] CROM_A;
    logic [7:0]    crom_q;
    logic          lcd_busy;
    logic          lcd_done;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_err;
    logic [7:0]    issued_cnt;

    logic [7:0] rom [0:31];
    logic [2:0] exp_q [$];
    int         n_tests;
    int         n_fails;
    int         busy_ctr;
    int         busy_len;
    logic       ack_en;
    logic       force_busy;

    lcd_cmd_sequencer #(
        .CROM_AW     (AW),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .CROM_EN    (CROM_EN),
        .CROM_A     (CROM_A),
        .CROM_Q     (crom_q),
        .lcd_busy   (lcd_busy),
        .lcd_done   (lcd_done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .seq_err    (seq_err),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command ROM with one-cycle read latency.
    always @(posedge clk) begin
        if (CROM_EN == 1'b0) crom_q <= rom[CROM_A];
    end

    // LCD_CTRL model: busy for busy_len cycles after each accepted strobe.
    always @(posedge clk or posedge reset) begin
        if (reset)                      busy_ctr <= 0;
        else if (cmd_valid && ack_en)   busy_ctr <= busy_len;
        else if (busy_ctr != 0)         busy_ctr <= busy_ctr - 1;
    end
    assign lcd_busy = force_busy | (busy_ctr != 0);

    // Scoreboard: every strobe must match the oldest expected command.
    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fails++;
                $error("FAIL unexpected_strobe: observed cmd=%0d, expected no strobe", cmd);
            end
            if (exp_q.size() != 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                n_tests++;
                assert (cmd === e) else begin
                    n_fails++;
                    $error("FAIL strobe_cmd: observed %0d expected %0d", cmd, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i;
        i = 0;
        while ((seq_busy === 1'b1) && (i < max)) begin
            tick(1);
            i++;
        end
        check(tag, (i < max) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_issued(input string tag, input logic [7:0] n, input int max);
        int i;
        i = 0;
        while ((issued_cnt !== n) && (i < max)) begin
            tick(1);
            i++;
        end
        check(tag, (i < max) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        logic [20:0] rst_obs;
        logic [20:0] rst_exp;
        logic        bad;
        int          lat;

        n_tests    = 0;
        n_fails    = 0;
        reset      = 1'b1;
        start      = 1'b0;
        lcd_done   = 1'b0;
        ack_en     = 1'b1;
        force_busy = 1'b0;
        busy_len   = 2;
        rst_exp    = {1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;

        // Basic single-command script ending on last
        do_reset();
        rst_obs = {CROM_EN, CROM_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, issued_cnt};
        check("reset_values", rst_obs, rst_exp);
        rom[0] = 8'h83;
        exp_q.push_back(3'd3);
        pulse_start();
        check("t1_busy_after_start", seq_busy, 1'b1);
        wait_idle("t1_finish", 100);
        check("t1_done", seq_done, 1'b1);
        check("t1_issued", issued_cnt, 8'd1);
        check("t1_crom_a", CROM_A, 5'd0);
        check("t1_cmd_hold", cmd, 3'd3);
        check("t1_queue_empty", exp_q.size(), 32'd0);

        // Repeat expansion followed by a Write that needs lcd_done
        rom[0] = 8'h19;
        rom[1] = 8'h00;
        for (int i = 0; i < 4; i++) exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        pulse_start();
        check("t2_done_cleared", seq_done, 1'b0);
        lcd_done = 1'b1;
        tick(1);
        lcd_done = 1'b0;
        wait_issued("t2_reach5", 8'd5, 200);
        tick(10);
        check("t2_wait_write_done", seq_done, 1'b0);
        check("t2_still_busy", seq_busy, 1'b1);
        lcd_done = 1'b1;
        tick(1);
        lcd_done = 1'b0;
        check("t2_done", seq_done, 1'b1);
        check("t2_not_busy", seq_busy, 1'b0);
        check("t2_issued", issued_cnt, 8'd5);
        check("t2_crom_a", CROM_A, 5'd1);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // Init gate: controller busy for 70 cycles after reset
        force_busy = 1'b1;
        do_reset();
        rom[0] = 8'h83;
        pulse_start();
        bad = 1'b0;
        for (int i = 0; i < 68; i++) begin
            if ((CROM_EN !== 1'b1) || (cmd_valid !== 1'b0)) bad = 1'b1;
            tick(1);
        end
        check("t3_no_fetch_while_busy", bad, 1'b0);
        check("t3_seq_busy", seq_busy, 1'b1);
        exp_q.push_back(3'd3);
        force_busy = 1'b0;
        tick(1);
        check("t3_fetch_next_cycle", CROM_EN, 1'b0);
        wait_idle("t3_finish", 100);
        check("t3_done", seq_done, 1'b1);

        // Acknowledge timeout
        ack_en = 1'b0;
        rom[0] = 8'h82;
        exp_q.push_back(3'd2);
        pulse_start();
        wait_issued("t4_strobe", 8'd1, 50);
        lat = 0;
        while ((seq_err !== 1'b1) && (lat < 40)) begin
            tick(1);
            lat++;
        end
        check("t4_err_latency", lat, ATO);
        check("t4_not_busy", seq_busy, 1'b0);
        tick(20);
        check("t4_no_more_strobes", issued_cnt, 8'd1);
        check("t4_err_sticky", seq_err, 1'b1);
        ack_en = 1'b1;
        exp_q.push_back(3'd2);
        pulse_start();
        check("t4_err_cleared", seq_err, 1'b0);
        check("t4_cnt_cleared", issued_cnt, 8'd0);
        wait_idle("t4_finish", 100);
        check("t4_done", seq_done, 1'b1);

        // Overrun: no last bit anywhere in the script
        for (int i = 0; i < 32; i++) begin
            rom[i] = 8'h05;
            exp_q.push_back(3'd5);
        end
        pulse_start();
        wait_idle("t5_finish", 2000);
        check("t5_err", seq_err, 1'b1);
        check("t5_done_low", seq_done, 1'b0);
        check("t5_issued", issued_cnt, 8'd32);
        check("t5_crom_a", CROM_A, 5'd31);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while executing a command
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h83;
        busy_len = 6;
        exp_q.push_back(3'd3);
        pulse_start();
        wait_issued("t6_strobe", 8'd1, 50);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        rst_obs = {CROM_EN, CROM_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, issued_cnt};
        check("t6_async_reset", rst_obs, rst_exp);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("t6_idle_after_reset", seq_busy, 1'b0);
        check("t6_no_issue", issued_cnt, 8'd0);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
